dmem_port_arbiter: RTL

Shares the single-port data memory between two requesters: port 0 is the CPU MEM stage and port 1 is the DMA/debug loader. Each cycle the block grants at most one word access. Writes commit on the clock edge. Read data returns through a registered response one cycle after grant. Port 0 has fixed priority, and a starvation counter guarantees port 1 forward progress. The block sits between the pipeline/DMA and the data memory's readAddress/writeAddress/writeData/memWrite/readData interface.

---
 rtl/dmem_port_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single-port data memory: CPU MEM stage (port 0)
// has fixed priority, a starvation counter guarantees the DMA/debug port (port 1) progress.
module dmem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,

    output logic [31:0] mem_readAddress,
    output logic [31:0] mem_writeAddress,
    output logic [31:0] mem_writeData,
    output logic        mem_memWrite,
    input  logic [31:0] mem_readData
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_p0_rvalid;
    logic             r_p1_rvalid;
    logic [31:0]      r_p0_rdata;
    logic [31:0]      r_p1_rdata;

    logic             w_favour1;
    logic             w_p0_gnt;
    logic             w_p1_gnt;
    logic             w_p0_rd;
    logic             w_p1_rd;

    // Port 1 overrides port 0 only once it has been denied STARVE_LIMIT cycles in a row.
    assign w_favour1 = (r_starve_cnt >= LIMIT);
    assign w_p1_gnt  = ~i_rst & p1_req & (~p0_req | w_favour1);
    assign w_p0_gnt  = ~i_rst & p0_req & ~w_p1_gnt;
    assign w_p0_rd   = w_p0_gnt & ~p0_we;
    assign w_p1_rd   = w_p1_gnt & ~p1_we;

    assign p0_gnt    = w_p0_gnt;
    assign p1_gnt    = w_p1_gnt;
    assign p0_rvalid = r_p0_rvalid;
    assign p1_rvalid = r_p1_rvalid;
    assign p0_rdata  = r_p0_rdata;
    assign p1_rdata  = r_p1_rdata;

    // NOTE: every output gets a default before the if-chain, so no latch is inferred.
    always_comb begin
        mem_readAddress  = '0;
        mem_writeAddress = '0;
        mem_writeData    = '0;
        mem_memWrite     = 1'b0;
        if (w_p1_gnt) begin
            mem_readAddress  = {p1_addr[31:2], 2'b00};
            mem_writeAddress = {p1_addr[31:2], 2'b00};
            mem_writeData    = p1_wdata;
            mem_memWrite     = p1_we;
        end else if (w_p0_gnt) begin
            mem_readAddress  = {p0_addr[31:2], 2'b00};
            mem_writeAddress = {p0_addr[31:2], 2'b00};
            mem_writeData    = p0_wdata;
            mem_memWrite     = p0_we;
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_starve_cnt <= '0;
            r_p0_rvalid  <= 1'b0;
            r_p1_rvalid  <= 1'b0;
            r_p0_rdata   <= '0;
            r_p1_rdata   <= '0;
        end else begin
            r_p0_rvalid <= w_p0_rd;
            r_p1_rvalid <= w_p1_rd;
            if (w_p0_rd) r_p0_rdata <= mem_readData;
            if (w_p1_rd) r_p1_rdata <= mem_readData;

            // A withdrawn request forfeits any accumulated starvation credit.
            if (w_p1_gnt || !p1_req) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt < LIMIT) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

endmodule
